// File: rtl/branchmux.sv
// Next-PC mux select encoding shared by fetch, decode and execute.
package branchmux;

  typedef enum logic [1:0] {
    pc_plus4 = 2'b00,
    br_taken = 2'b01,
    jalr_tgt = 2'b10
  } branchmux_sel_t;

endpackage

// File: rtl/rv32i_types.sv
// RV32I shared widths, opcode constants and the ID/EX payload.
package rv32i_types;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   ir;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic              illegal;
  } id_ex_t;

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 architectural register file: one write port, two comb read ports
// that see a same-cycle writeback.
module regfile
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1_c,
  output logic [XLEN-1:0]   rdata2_c
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // x0 reads as zero; a matching writeback bypasses the array
  always_comb begin
    rdata1_c = '0;
    rdata2_c = '0;
    if (raddr1 != '0) rdata1_c = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
    if (raddr2 != '0) rdata2_c = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, register file, immediate generation,
// load-use stall and branch flush, feeding the ID/EX register.
module id_stage
  import rv32i_types::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [XLEN-1:0]           IR_regs_in,
  input  logic [XLEN-1:0]           if_pc,
  input  branchmux::branchmux_sel_t branchmux_sel,
  input  logic                      wb_load,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  output logic                      stall_if,
  output logic                      ex_valid,
  output logic [XLEN-1:0]           ex_pc,
  output logic [XLEN-1:0]           ex_ir,
  output logic [XLEN-1:0]           ex_rs1_data,
  output logic [XLEN-1:0]           ex_rs2_data,
  output logic [XLEN-1:0]           ex_imm,
  output logic [REG_AW-1:0]         ex_rd,
  output logic                      ex_illegal
);

  logic [XLEN-1:0]   ifid_ir;
  logic [XLEN-1:0]   ifid_pc;
  logic              ifid_valid;
  logic              flush;
  logic [6:0]        opcode;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [XLEN-1:0]   imm;
  logic              illegal;
  logic              use_rs1;
  logic              use_rs2;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  id_ex_t            ex_q;
  id_ex_t            ex_d;

  assign flush = (branchmux_sel == branchmux::br_taken);

  // IF/ID: flush beats stall beats load
  always_ff @(posedge clk) begin
    if (!reset) begin
      ifid_ir    <= '0;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
    end else if (flush) begin
      ifid_ir    <= '0;
      ifid_valid <= 1'b0;
    end else if (!stall_if) begin
      ifid_ir    <= IR_regs_in;
      ifid_pc    <= if_pc;
      ifid_valid <= (IR_regs_in != '0);
    end
  end

  assign opcode = ifid_ir[6:0];
  assign rd     = ifid_ir[11:7];
  assign rs1    = ifid_ir[19:15];
  assign rs2    = ifid_ir[24:20];

  // Immediate format and source usage by opcode
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      LOAD, OP_IMM, JALR: begin
        imm     = {{20{ifid_ir[31]}}, ifid_ir[31:20]};
        use_rs1 = 1'b1;
      end
      STORE: begin
        imm     = {{20{ifid_ir[31]}}, ifid_ir[31:25], ifid_ir[11:7]};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      BRANCH: begin
        imm     = {{19{ifid_ir[31]}}, ifid_ir[31], ifid_ir[7], ifid_ir[30:25],
                   ifid_ir[11:8], 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      LUI, AUIPC: imm = {ifid_ir[31:12], 12'b0};
      JAL: imm = {{11{ifid_ir[31]}}, ifid_ir[31], ifid_ir[19:12], ifid_ir[20],
                  ifid_ir[30:21], 1'b0};
      OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: illegal = ifid_valid;
    endcase
  end

  regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (wb_load),
    .waddr    (wb_rd),
    .wdata    (wb_data),
    .raddr1   (rs1),
    .raddr2   (rs2),
    .rdata1_c (rs1_data),
    .rdata2_c (rs2_data)
  );

  // Load in EX whose destination the decoding instruction reads
  assign stall_if = ex_q.valid && (ex_q.ir[6:0] == LOAD) && (ex_q.rd != '0) &&
                    ((use_rs1 && (rs1 == ex_q.rd)) || (use_rs2 && (rs2 == ex_q.rd))) &&
                    ifid_valid && !flush;

  always_comb begin
    ex_d = '0;
    if (!flush && !stall_if) begin
      ex_d.valid    = ifid_valid;
      ex_d.pc       = ifid_pc;
      ex_d.ir       = ifid_ir;
      ex_d.rs1_data = rs1_data;
      ex_d.rs2_data = rs2_data;
      ex_d.imm      = imm;
      ex_d.rd       = rd;
      ex_d.illegal  = illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_ir       = ex_q.ir;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rd       = ex_q.rd;
  assign ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage with a format-level pipeline model checked every cycle.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] IR_regs_in = '0;
  logic [31:0] if_pc = '0;
  branchmux::branchmux_sel_t branchmux_sel = branchmux::pc_plus4;
  logic        wb_load = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        stall_if;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_ir, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_illegal;

  int total = 0;
  int bad = 0;
  logic armed = 1'b0;

  id_stage dut (
    .clk(clk), .reset(reset), .IR_regs_in(IR_regs_in), .if_pc(if_pc),
    .branchmux_sel(branchmux_sel), .wb_load(wb_load), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_if(stall_if), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ir(ex_ir),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [31:0] pc, ir, a, b, imm; logic [4:0] rd; logic ill;
  } exp_t;

  // Model state
  logic [31:0] m_rf [32];
  logic [31:0] m_ir = '0;
  logic [31:0] m_pc = '0;
  logic        m_v = 1'b0;
  exp_t        m_ex = '0;

  initial for (int i = 0; i < 32; i++) m_rf[i] = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int w);
    logic signed [31:0] x;
    x = v << (32 - w);
    return 32'(x >>> (32 - w));
  endfunction

  // Instruction format letter from opcode
  function automatic byte fmt(input logic [31:0] ir);
    case (ir[6:0])
      7'h03, 7'h13, 7'h67: return "I";
      7'h23: return "S";
      7'h63: return "B";
      7'h37, 7'h17: return "U";
      7'h6F: return "J";
      7'h33: return "R";
      default: return "X";
    endcase
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] ir);
    case (fmt(ir))
      "I": return sext({20'b0, ir[31:20]}, 12);
      "S": return sext({20'b0, ir[31:25], ir[11:7]}, 12);
      "B": return sext({19'b0, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}, 13);
      "U": return ir & 32'hFFFFF000;
      "J": return sext({11'b0, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}, 21);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic reads_reg(input logic [31:0] ir, input logic [4:0] r);
    byte f;
    f = fmt(ir);
    if ((f == "I" || f == "S" || f == "B" || f == "R") && ir[19:15] == r) return 1'b1;
    if ((f == "S" || f == "B" || f == "R") && ir[24:20] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wb_load && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic logic m_stall();
    return m_ex.v && m_ex.ir[6:0] == 7'h03 && m_ex.rd != 5'd0 && m_v &&
           reads_reg(m_ir, m_ex.rd) && branchmux_sel != branchmux::br_taken;
  endfunction

  // Pipeline model
  always @(posedge clk) begin
    exp_t nx;
    logic stall;
    stall = m_stall();
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] <= '0;
      m_ir <= '0; m_pc <= '0; m_v <= 1'b0; m_ex <= '0;
    end else begin
      if (wb_load && wb_rd != 5'd0) m_rf[wb_rd] <= wb_data;
      nx = '0;
      if (branchmux_sel == branchmux::br_taken) begin
        m_ir <= '0; m_v <= 1'b0;
      end else if (!stall) begin
        m_ir <= IR_regs_in; m_pc <= if_pc; m_v <= (IR_regs_in != 0);
        nx.v = m_v; nx.pc = m_pc; nx.ir = m_ir;
        nx.a = m_read(m_ir[19:15]); nx.b = m_read(m_ir[24:20]);
        nx.imm = m_imm(m_ir); nx.rd = m_ir[11:7];
        nx.ill = m_v && fmt(m_ir) == "X";
      end
      m_ex <= nx;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (armed) begin
      check("stall_if", {31'b0, stall_if}, {31'b0, m_stall()});
      check("ex_valid", {31'b0, ex_valid}, {31'b0, m_ex.v});
      if (m_ex.v) begin
        check("ex_pc", ex_pc, m_ex.pc);
        check("ex_ir", ex_ir, m_ex.ir);
        check("ex_rs1_data", ex_rs1_data, m_ex.a);
        check("ex_rs2_data", ex_rs2_data, m_ex.b);
        check("ex_imm", ex_imm, m_ex.imm);
        check("ex_rd", {27'b0, ex_rd}, {27'b0, m_ex.rd});
        check("ex_illegal", {31'b0, ex_illegal}, {31'b0, m_ex.ill});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ir, input logic [31:0] pc);
    IR_regs_in = ir;
    if_pc = pc;
  endtask

  task automatic check_ex_zero(input string tag);
    check({tag, "_valid"}, {31'b0, ex_valid}, 32'h0);
    check({tag, "_pc"}, ex_pc, 32'h0);
    check({tag, "_ir"}, ex_ir, 32'h0);
    check({tag, "_rs1"}, ex_rs1_data, 32'h0);
    check({tag, "_rs2"}, ex_rs2_data, 32'h0);
    check({tag, "_imm"}, ex_imm, 32'h0);
    check({tag, "_rd"}, {27'b0, ex_rd}, 32'h0);
    check({tag, "_ill"}, {31'b0, ex_illegal}, 32'h0);
    check({tag, "_stall"}, {31'b0, stall_if}, 32'h0);
  endtask

  localparam logic [31:0] ADDI_X1 = 32'h00500093;
  localparam logic [31:0] ADD_433 = 32'h00018233;
  localparam logic [31:0] ADD_703 = 32'h003003B3;
  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] ADD_652 = 32'h00228333;
  localparam logic [31:0] LW_X0   = 32'h0000A003;
  localparam logic [31:0] ADD_600 = 32'h00000333;
  localparam logic [31:0] LUI_X5  = 32'h123452B7;
  localparam logic [31:0] BEQ_M8  = 32'hFE000CE3;
  localparam logic [31:0] JAL_2K  = 32'h0010006F;
  localparam logic [31:0] BAD_OPC = 32'h0000007F;

  initial begin
    // Reset
    reset = 1'b0;
    step(); step();
    armed = 1'b1;
    check_ex_zero("rst");
    reset = 1'b1;

    // Basic addi, two-edge latency
    fetch(ADDI_X1, 32'h40); step();
    fetch(32'h0, 32'h44); step();
    check("addi_valid", {31'b0, ex_valid}, 32'h1);
    check("addi_imm", ex_imm, 32'h5);
    check("addi_rd", {27'b0, ex_rd}, 32'h1);
    check("addi_pc", ex_pc, 32'h40);
    check("addi_stall", {31'b0, stall_if}, 32'h0);

    // Writeback bypass into decode
    fetch(ADD_433, 32'h50); step();
    fetch(32'h0, 32'h54);
    wb_load = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    step();
    wb_load = 1'b0;
    check("bypass_rs1", ex_rs1_data, 32'hDEADBEEF);
    check("bypass_rs2", ex_rs2_data, 32'h0);

    // Writes to x0 are dropped, stored x3 read back
    fetch(ADD_703, 32'h60);
    wb_load = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
    step();
    fetch(32'h0, 32'h64); step();
    wb_load = 1'b0;
    check("x0_rs1", ex_rs1_data, 32'h0);
    check("x3_rs2", ex_rs2_data, 32'hDEADBEEF);

    // Load-use: one stall cycle, one bubble
    fetch(LW_X5, 32'h100); step();
    fetch(ADD_652, 32'h104); step();
    check("lu_stall", {31'b0, stall_if}, 32'h1);
    step();
    check("lu_bubble", {31'b0, ex_valid}, 32'h0);
    check("lu_stall_gone", {31'b0, stall_if}, 32'h0);
    fetch(32'h0, 32'h108); step();
    check("lu_add_valid", {31'b0, ex_valid}, 32'h1);
    check("lu_add_ir", ex_ir, ADD_652);
    check("lu_add_pc", ex_pc, 32'h104);

    // No stall for load to x0 or for a non-reading consumer
    fetch(LW_X0, 32'h200); step();
    fetch(ADD_600, 32'h204); step();
    check("lw_x0_nostall", {31'b0, stall_if}, 32'h0);
    fetch(LW_X5, 32'h208); step();
    fetch(LUI_X5, 32'h20C); step();
    check("lui_nostall", {31'b0, stall_if}, 32'h0);
    fetch(32'h0, 32'h210); step(); step();

    // Flush suppresses a pending load-use stall
    fetch(LW_X5, 32'h300); step();
    fetch(ADD_652, 32'h304); step();
    branchmux_sel = branchmux::br_taken;
    #1;
    check("flush_nostall", {31'b0, stall_if}, 32'h0);
    step();
    branchmux_sel = branchmux::pc_plus4;
    fetch(32'h0, 32'h400);
    check("flush_ex_bubble", {31'b0, ex_valid}, 32'h0);
    step();
    check("flush_ifid_clear", {31'b0, ex_valid}, 32'h0);

    // Immediate encodings and illegal opcode
    fetch(BEQ_M8, 32'h400); step();
    fetch(JAL_2K, 32'h404); step();
    check("beq_imm", ex_imm, 32'hFFFFFFF8);
    fetch(BAD_OPC, 32'h408); step();
    check("jal_imm", ex_imm, 32'h00000800);
    fetch(32'h0, 32'h40C); step();
    check("bad_illegal", {31'b0, ex_illegal}, 32'h1);
    check("bad_imm", ex_imm, 32'h0);
    check("bad_valid", {31'b0, ex_valid}, 32'h1);
    step();

    // Reset in the middle of a stall
    fetch(LW_X5, 32'h500); step();
    fetch(ADD_652, 32'h504); step();
    check("pre_rst_stall", {31'b0, stall_if}, 32'h1);
    reset = 1'b0;
    step();
    check_ex_zero("midrst");
    reset = 1'b1;
    fetch(32'h0, 32'h0);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
